prod_accum: RTL and testbench
=============================

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter data_width, default from shared package (4), operand width of the upstream multiplier.
REQ-002 SHALL have parameter n_prod, default 4, products per burst; legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port rdy  input  1  multiplier done level; a product is presented when rdy rises.
REQ-006 SHALL have port P  input  2*data_width  multiplier product, valid when rdy is high.
REQ-007 SHALL have port clr  input  1  synchronous datapath clear.
REQ-008 SHALL have port start  output  1  multiplier start enable (backpressure).
REQ-009 SHALL have port sum  output  acc_width  burst sum, acc_width = 2*data_width + clog2(n_prod).
REQ-010 SHALL have port sum_valid  output  1  sum holds a complete burst.
REQ-011 SHALL have port sum_ready  input  1  consumer accepts sum.
REQ-012 SHALL have port drop  output  1  sticky flag: a product was lost.

Function
REQ-013 SHALL detect capture as rdy & ~rdy_q, with rdy_q the registered rdy; capture samples P in the same cycle.
REQ-014 SHALL implement FSM states ACCUM and HOLD.
REQ-015 In ACCUM, each capture SHALL add P (zero-extended) to acc and increment cnt.
REQ-016 ACCUM SHALL go to HOLD in the cycle after the capture that makes cnt == n_prod; sum = acc and sum_valid = 1 from that cycle on.
REQ-017 In HOLD, sum and sum_valid SHALL stay stable until the cycle sum_valid & sum_ready is sampled high.
REQ-018 In HOLD, a capture with the pending register empty SHALL store P in pending (1 entry).
REQ-019 In HOLD, a capture with pending full and no handshake SHALL discard P and set drop.
REQ-020 A handshake with pending empty and no capture SHALL go to ACCUM with acc = 0, cnt = 0.
REQ-021 A handshake with pending empty and a capture in the same cycle SHALL go to ACCUM with acc = P, cnt = 1.
REQ-022 A handshake with pending full SHALL go to ACCUM with acc = pending and cnt = 1; pending is cleared. If a capture also occurs in that cycle, P SHALL be stored in pending instead.
REQ-023 start SHALL be 1 except when in HOLD with pending full, or during reset.
REQ-024 Arithmetic SHALL be unsigned; acc_width SHALL guarantee no overflow for n_prod maximal products.
REQ-025 clr SHALL return FSM, acc, cnt and pending to reset values and clear drop; rdy_q SHALL still track rdy.
REQ-026 Priority SHALL be rst > clr > handshake/capture.

Reset
REQ-027 On rst: state = ACCUM, acc = 0, cnt = 0, pending empty, sum = 0, sum_valid = 0, drop = 0, start = 0.
REQ-028 rdy_q SHALL reset to 1, so a rdy level already high when reset releases is not captured.
REQ-029 Reset asserted mid-burst or in HOLD SHALL discard all partial and pending data with no sum_valid pulse.

Structure
REQ-030 data_width, n_prod default, acc_width and the FSM state enum typedef SHALL live in the shared package q_8_39_pkg.
REQ-031 Rising-edge detection SHALL be a sub-module rise_det (clk, rst, d, rise), with internal register reset to 1.

Verification
REQ-032 Burst: data_width 4, n_prod 4; products 15, 14, 225, 1 -> sum = 255, sum_valid high until sum_ready.
REQ-033 Maximum burst: four products of 225 -> sum = 900, no wrap in a 10-bit sum.
REQ-034 Backpressure: hold sum_ready = 0; 1st extra product 6 goes to pending and start drops to 0; 2nd extra product is discarded -> drop = 1. Then sum_ready = 1 -> next burst starts with acc = 6, cnt = 1.
REQ-035 Simultaneous events: handshake in the same cycle as capture of 9 with pending empty -> ACCUM, acc = 9, cnt = 1.
REQ-036 Reset: rst after 2 of 4 products, rdy held high across release -> no capture; next 4 products give only their own sum.
REQ-037 Clear: clr while drop = 1 in HOLD -> drop = 0, sum_valid = 0, acc = 0, start = 1.

Source files
------------

// File: rtl/q_8_39_pkg.sv
// Shared defaults and types for the product accumulator.
package q_8_39_pkg;

  localparam int def_data_width = 4;
  localparam int def_n_prod     = 4;

  // n_prod worst-case products of 2*dw bits each fit without wrap
  function automatic int acc_width_f(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  localparam int def_acc_width = acc_width_f(def_data_width, def_n_prod);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/prod_accum_rise_det.sv
// Rising-edge detector; register resets high so a level already high at
// reset release is not seen as an edge.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b1;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/prod_accum.sv
// Accumulates n_prod multiplier products into a burst sum, holding the sum
// for a ready/valid consumer with a single-entry overflow register.
module prod_accum
  import q_8_39_pkg::*;
#(
  parameter  int data_width = def_data_width,
  parameter  int n_prod     = def_n_prod,
  localparam int acc_width  = acc_width_f(data_width, n_prod)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [2*data_width-1:0] P,
  input  logic                    clr,
  output logic                    start,
  output logic [acc_width-1:0]    sum,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic                    drop
);

  localparam int cnt_w = $clog2(n_prod + 1);

  state_t                  state, state_n;
  logic [acc_width-1:0]    acc;
  logic [cnt_w-1:0]        cnt;
  logic [2*data_width-1:0] pend;
  logic                    pend_vld;
  logic                    cap;
  logic                    hs;
  logic                    last_cap;

  // clr deliberately does not touch the edge detector so rdy keeps being tracked
  rise_det u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (rdy),
    .rise (cap)
  );

  assign last_cap = cap && (cnt == cnt_w'(n_prod - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ACCUM: if (last_cap) state_n = HOLD;
      HOLD:  if (hs)       state_n = ACCUM;
      default:             state_n = ACCUM;
    endcase
    if (clr) state_n = ACCUM;
  end

  always_comb begin
    sum_valid = (state == HOLD);
    hs        = sum_valid & sum_ready;
    start     = ~rst & ~((state == HOLD) & pend_vld);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc      <= '0;
      cnt      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      drop     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (cap) begin
            acc <= acc + acc_width'(P);
            cnt <= cnt + cnt_w'(1);
          end
        end
        HOLD: begin
          if (hs) begin
            // pending entry seeds the next burst; a simultaneous capture refills it
            if (pend_vld) begin
              acc      <= acc_width'(pend);
              cnt      <= cnt_w'(1);
              pend_vld <= cap;
              if (cap) pend <= P;
            end else if (cap) begin
              acc <= acc_width'(P);
              cnt <= cnt_w'(1);
            end else begin
              acc <= '0;
              cnt <= '0;
            end
          end else if (cap) begin
            if (!pend_vld) begin
              pend     <= P;
              pend_vld <= 1'b1;
            end else begin
              drop <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = acc;

endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;

  localparam int dw = 4;
  localparam int np = 4;
  localparam int aw = 2 * dw + $clog2(np);

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [2*dw-1:0] P;
  logic          clr;
  logic          start;
  logic [aw-1:0] sum;
  logic          sum_valid;
  logic          sum_ready;
  logic          drop;

  int errs   = 0;
  int checks = 0;

  prod_accum #(.data_width(dw), .n_prod(np)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .P         (P),
    .clr       (clr),
    .start     (start),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one rdy pulse; the capture edge is the posedge ending the pulse
  task automatic prod(input logic [2*dw-1:0] p);
    tick();
    P   = p;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic handshake();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; P = '0; clr = 1'b0; sum_ready = 1'b0;
    tick(); tick();
    chk("rst_start", start, 0);
    chk("rst_sum", sum, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_drop", drop, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_start", start, 1);

    // basic burst
    prod(15); prod(14); prod(225);
    chk("b1_partial_sum", sum, 254);
    chk("b1_partial_valid", sum_valid, 0);
    prod(1);
    chk("b1_sum", sum, 255);
    chk("b1_valid", sum_valid, 1);
    tick(); tick(); tick();
    chk("b1_hold_sum", sum, 255);
    chk("b1_hold_valid", sum_valid, 1);
    handshake();
    chk("b1_hs_valid", sum_valid, 0);
    chk("b1_hs_sum", sum, 0);
    chk("b1_hs_cnt", dut.cnt, 0);

    // maximum burst
    prod(225); prod(225); prod(225); prod(225);
    chk("max_sum", sum, 900);
    chk("max_valid", sum_valid, 1);
    handshake();

    // backpressure: pending fill then drop
    prod(1); prod(2); prod(3); prod(4);
    chk("bp_sum", sum, 10);
    prod(6);
    chk("bp_pend_start", start, 0);
    chk("bp_pend_drop", drop, 0);
    chk("bp_pend_sum", sum, 10);
    prod(7);
    chk("bp_drop", drop, 1);
    chk("bp_drop_sum", sum, 10);
    chk("bp_drop_valid", sum_valid, 1);
    handshake();
    chk("bp_hs_sum", sum, 6);
    chk("bp_hs_cnt", dut.cnt, 1);
    chk("bp_hs_valid", sum_valid, 0);
    chk("bp_hs_start", start, 1);
    chk("bp_hs_drop_sticky", drop, 1);
    prod(1); prod(1); prod(1);
    chk("bp_b2_sum", sum, 9);
    chk("bp_b2_valid", sum_valid, 1);

    // clear while in HOLD with drop set
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_drop", drop, 0);
    chk("clr_valid", sum_valid, 0);
    chk("clr_sum", sum, 0);
    chk("clr_start", start, 1);
    chk("clr_cnt", dut.cnt, 0);

    // handshake coinciding with capture, pending empty
    prod(2); prod(2); prod(2); prod(2);
    chk("sim_sum", sum, 8);
    tick();
    P = 9; rdy = 1'b1; sum_ready = 1'b1;
    tick();
    rdy = 1'b0; sum_ready = 1'b0;
    chk("sim_sum_after", sum, 9);
    chk("sim_cnt", dut.cnt, 1);
    chk("sim_valid", sum_valid, 0);
    prod(1); prod(1); prod(1);
    chk("sim_b2_sum", sum, 12);
    handshake();

    // handshake with pending full and simultaneous capture
    prod(1); prod(1); prod(1); prod(1);
    prod(8);
    chk("pf_start", start, 0);
    tick();
    P = 3; rdy = 1'b1; sum_ready = 1'b1;
    tick();
    rdy = 1'b0; sum_ready = 1'b0;
    chk("pf_hs_sum", sum, 8);
    chk("pf_hs_cnt", dut.cnt, 1);
    chk("pf_hs_start", start, 1);
    prod(1); prod(1); prod(1);
    chk("pf_b2_sum", sum, 11);
    chk("pf_b2_start", start, 0);
    handshake();
    chk("pf_b3_sum", sum, 3);
    chk("pf_b3_cnt", dut.cnt, 1);

    // reset mid-burst with rdy held high across release
    prod(5);
    chk("mr_sum", sum, 8);
    tick();
    P = 7; rdy = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("mr_sum_rst", sum, 0);
    chk("mr_cnt_rst", dut.cnt, 0);
    chk("mr_valid_rst", sum_valid, 0);
    rdy = 1'b0;
    prod(3); prod(4); prod(5);
    chk("mr_valid_partial", sum_valid, 0);
    prod(6);
    chk("mr_sum_burst", sum, 18);
    chk("mr_valid_burst", sum_valid, 1);
    handshake();
    chk("mr_final_valid", sum_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
